// File: rtl/anubis_pkg.sv
// Shared types and default widths for the anubis request/response controller.
package anubis_pkg;

  localparam int unsigned ANUBIS_TW = 128;
  localparam int unsigned ANUBIS_KW = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/anubis_req_ctrl.sv
// Wraps the anubis core's reset-as-start / end_flag-as-done protocol in a
// single-job valid/ready request and response interface with a run timeout.
module anubis_req_ctrl
  import anubis_pkg::*;
#(
  parameter int unsigned TW             = ANUBIS_TW,
  parameter int unsigned KW             = ANUBIS_KW,
  parameter int unsigned TAGW           = 8,
  parameter int unsigned START_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_encrypt,
  input  logic [TW-1:0]   req_text,
  input  logic [KW-1:0]   req_key,
  input  logic [TAGW-1:0] req_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [TW-1:0]   rsp_data,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_timeout,
  output logic            busy,
  output logic            core_reset,
  output logic            core_encrypt,
  output logic [TW-1:0]   core_text,
  output logic [KW-1:0]   core_key,
  input  logic [TW-1:0]   core_cipher,
  input  logic            core_end
);

  localparam int unsigned CW  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int unsigned TMW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_INIT = CW'(START_CYCLES - 1);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [TMW-1:0]  tmo;
  logic            end_q;
  logic [TAGW-1:0] tag_q;
  logic            done;

  // end_q tracks core_end in every state, so a level that is already high
  // when RUN begins never looks like a rising edge.
  assign done = core_end & ~end_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      tmo          <= '0;
      end_q        <= 1'b0;
      tag_q        <= '0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_tag      <= '0;
      rsp_timeout  <= 1'b0;
      busy         <= 1'b0;
      core_reset   <= 1'b1;
      core_encrypt <= 1'b0;
      core_text    <= '0;
      core_key     <= '0;
    end else begin
      end_q <= core_end;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            core_encrypt <= req_encrypt;
            core_text    <= req_text;
            core_key     <= req_key;
            tag_q        <= req_tag;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
            cnt          <= CNT_INIT;
            state        <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            core_reset <= 1'b0;
            tmo        <= '0;
            state      <= RUN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (done) begin
            rsp_data    <= core_cipher;
            rsp_tag     <= tag_q;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            core_reset  <= 1'b1;
            state       <= RESP;
          end else if (tmo == TMO_LAST) begin
            rsp_data    <= '0;
            rsp_tag     <= tag_q;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            core_reset  <= 1'b1;
            state       <= RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_anubis_req_ctrl.sv
// Randomised scoreboard bench for anubis_req_ctrl with a stub core model.
module tb_anubis_req_ctrl;

  localparam int unsigned S   = 2;
  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_encrypt = 1'b0;
  logic [127:0] req_text = '0;
  logic [127:0] req_key = '0;
  logic [7:0]   req_tag = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic [7:0]   rsp_tag;
  logic         rsp_timeout;
  logic         busy;
  logic         core_reset;
  logic         core_encrypt;
  logic [127:0] core_text;
  logic [127:0] core_key;
  logic [127:0] core_cipher;
  logic         core_end;

  anubis_req_ctrl #(
    .TW(128), .KW(128), .TAGW(8), .START_CYCLES(S), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_encrypt(req_encrypt),
    .req_text(req_text), .req_key(req_key), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout), .busy(busy),
    .core_reset(core_reset), .core_encrypt(core_encrypt), .core_text(core_text),
    .core_key(core_key), .core_cipher(core_cipher), .core_end(core_end)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub core: mode 0 ends N clocks after leaving reset, 1 never ends,
  // 2 holds end_flag high permanently.
  int          stub_mode = 0;
  int unsigned stub_n = 1;
  int unsigned stub_cnt = 0;
  logic        stub_end = 1'b0;
  always @(posedge clk) begin
    if (core_reset) begin
      stub_cnt <= 0;
      stub_end <= (stub_mode == 2);
    end else if (stub_mode == 0 && !stub_end) begin
      if (stub_cnt == stub_n - 1) stub_end <= 1'b1;
      else stub_cnt <= stub_cnt + 1;
    end
  end
  assign core_end    = stub_end;
  assign core_cipher = core_text ^ core_key;

  typedef struct {
    logic [127:0] data;
    logic [7:0]   tag;
    logic         tmo;
    int unsigned  cyc;
    int unsigned  hold;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_tag"}, rsp_tag, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_core_encrypt"}, core_encrypt, 0);
    chk({tag, "_core_text"}, core_text, 0);
    chk({tag, "_core_key"}, core_key, 0);
  endtask

  // Monitor: pops the scoreboard on each rsp_valid rise and owns rsp_ready.
  logic         prev_valid = 1'b0;
  logic [127:0] cap_data;
  logic [7:0]   cap_tag;
  logic         cap_tmo;
  int unsigned  hold_left = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (busy) chk("no_accept_while_busy", req_ready, 0);
      if (rsp_valid) begin
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=tag %0h required=none", rsp_tag);
            hold_left = 0;
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_tag", rsp_tag, e.tag);
            chk("rsp_timeout", rsp_timeout, e.tmo);
            chk("rsp_latency", cyc, e.cyc);
            hold_left = e.hold;
          end
          cap_data = rsp_data;
          cap_tag  = rsp_tag;
          cap_tmo  = rsp_timeout;
        end else begin
          chk("rsp_data_stable", rsp_data, cap_data);
          chk("rsp_tag_stable", rsp_tag, cap_tag);
          chk("rsp_tmo_stable", rsp_timeout, cap_tmo);
        end
        chk("core_reset_in_resp", core_reset, 1);
        if (hold_left > 0) begin
          rsp_ready = 1'b0;
          hold_left--;
        end else begin
          rsp_ready = 1'b1;
        end
      end else begin
        rsp_ready = $urandom_range(0, 1) == 1;
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic send(input logic enc, input logic [127:0] text, input logic [127:0] key,
                      input logic [7:0] tag, input int mode, input int unsigned n,
                      input int unsigned hold);
    int unsigned w;
    int unsigned acc;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_req_ready actual=0 required=1 after %0d cycles", w);
      return;
    end
    stub_mode   = mode;
    stub_n      = n;
    req_valid   = 1'b1;
    req_encrypt = enc;
    req_text    = text;
    req_key     = key;
    req_tag     = tag;
    acc = cyc + 1;
    e.tmo  = (mode != 0) || (n + 1 > TMO);
    e.data = e.tmo ? 128'h0 : (text ^ key);
    e.tag  = tag;
    e.cyc  = acc + S + (e.tmo ? TMO : n + 1);
    e.hold = hold;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("core_encrypt", core_encrypt, enc);
    chk("core_text", core_text, text);
    chk("core_key", core_key, key);
    req_text    = {$urandom, $urandom, $urandom, $urandom};
    req_key     = {$urandom, $urandom, $urandom, $urandom};
    req_encrypt = ~enc;
    for (int i = 0; i < int'(S); i++) begin
      chk("core_reset_start", core_reset, 1);
      @(negedge clk);
    end
    chk("core_reset_run", core_reset, 0);
    chk("core_text_stable", core_text, text);
    chk("core_key_stable", core_key, key);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);
    chk("post_rel_req_ready", req_ready, 1);
    chk("post_rel_core_reset", core_reset, 1);
    chk("post_rel_rsp_valid", rsp_valid, 0);
    chk("post_rel_busy", busy, 0);

    send(1'b1, 128'h1, 128'h2, 8'h5A, 0, 10, 0);
    send(1'b1, 128'h1, 128'h2, 8'h5A, 0, 10, 5);
    send(1'b0, {4{$urandom}}, {4{$urandom}}, 8'h11, 1, 1, 1);
    send(1'b1, {4{$urandom}}, {4{$urandom}}, 8'h22, 2, 1, 0);
    send(1'b1, {4{$urandom}}, {4{$urandom}}, 8'h33, 0, TMO - 1, 0);
    send(1'b0, {4{$urandom}}, {4{$urandom}}, 8'h44, 0, TMO, 2);
    send(1'b1, {4{$urandom}}, {4{$urandom}}, 8'h55, 0, 1, 0);

    send(1'b1, {4{$urandom}}, {4{$urandom}}, 8'h66, 0, 10, 0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("mid_reset");
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rerel_req_ready", req_ready, 1);
    send(1'b0, 128'hABCD, 128'h1234, 8'h01, 0, 7, 2);

    for (int j = 0; j < 12; j++) begin
      int m;
      m = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      send(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 8'($urandom),
           m, $urandom_range(1, 18), $urandom_range(0, 3));
    end

    begin
      int unsigned w;
      w = 0;
      while ((sb.size() != 0 || busy) && w < 300) begin
        @(negedge clk);
        w++;
      end
      chk("drain_pending", sb.size(), 0);
      chk("drain_busy", busy, 0);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
